// File: rtl/elevator_scan_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// elevator_scan_ctrl : single-car SCAN elevator controller, one per shaft
// Rev 1.0
// ------------------------------------------------------------------------
module elevator_scan_ctrl #(
  parameter int FLOORS     = 8,
  parameter int FLOOR_W    = 3,
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  car_req,
  input  logic [FLOORS-1:0]  hall_up,
  input  logic [FLOORS-1:0]  hall_dn,
  input  logic               door_hold,
  output logic [FLOOR_W-1:0] floor,
  output logic [1:0]         dir,
  output logic               moving,
  output logic               door_open,
  output logic [FLOORS-1:0]  pend_car,
  output logic [FLOORS-1:0]  pend_up,
  output logic [FLOORS-1:0]  pend_dn
);

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  localparam int CNT_MAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]   TRAVEL_INIT = CNT_W'(TRAVEL_CYC - 1);
  localparam logic [CNT_W-1:0]   DOOR_INIT   = CNT_W'(DOOR_CYC - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(FLOORS - 1);
  localparam logic [FLOORS-1:0]  UP_MASK     = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0]  DN_MASK     = {{(FLOORS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  // Request bits cleared when the current door opened; re-presses of these
  // extend the dwell instead of re-latching.
  logic [FLOORS-1:0]  clr_car, clr_up, clr_dn;

  function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] r;
    r = '0;
    for (int i = 0; i < FLOORS; i++)
      if (i == int'(f)) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic ahead_of(input logic [FLOORS-1:0] req,
                                    input logic [FLOOR_W-1:0] f,
                                    input logic up);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (up ? (i > int'(f)) : (i < int'(f))) r = r | req[i];
    return r;
  endfunction

  logic [FLOORS-1:0]  any_req, here_oh, nf_oh, open_oh;
  logic [FLOORS-1:0]  ent_car, ent_up, ent_dn;
  logic [FLOORS-1:0]  up_in, dn_in, car_set, up_set, dn_set;
  logic [FLOOR_W-1:0] nf;
  logic               here, above, below, going_up, ahead_nf;
  logic               same_nf, opp_nf, at_end, stop_nf;
  logic               idle_open, move_open, in_door, press_reload;
  logic [1:0]         go_dir;

  always_comb begin
    any_req  = pend_car | pend_up | pend_dn;
    here_oh  = onehot(floor);
    here     = |(any_req & here_oh);
    above    = ahead_of(any_req, floor, 1'b1);
    below    = ahead_of(any_req, floor, 1'b0);

    // Arrival decision is made against the floor being entered.
    going_up = (dir == DIR_UP);
    nf       = going_up ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
    nf_oh    = onehot(nf);
    ahead_nf = ahead_of(any_req, nf, going_up);
    same_nf  = going_up ? |(pend_up & nf_oh) : |(pend_dn & nf_oh);
    opp_nf   = going_up ? |(pend_dn & nf_oh) : |(pend_up & nf_oh);
    at_end   = going_up ? (nf == TOP_FLOOR) : (nf == '0);
    stop_nf  = |(pend_car & nf_oh) | same_nf | (opp_nf & ~ahead_nf) | at_end;

    idle_open = (state == S_IDLE) && here;
    move_open = (state == S_MOVE) && (cnt == '0) && stop_nf;
    open_oh   = idle_open ? here_oh : nf_oh;
    ent_car   = (idle_open || move_open) ? open_oh : '0;
    ent_up    = (idle_open || (move_open && (going_up || !ahead_nf)))  ? open_oh : '0;
    ent_dn    = (idle_open || (move_open && (!going_up || !ahead_nf))) ? open_oh : '0;

    in_door      = (state == S_DOOR);
    up_in        = hall_up & UP_MASK;
    dn_in        = hall_dn & DN_MASK;
    press_reload = in_door && |((car_req & clr_car) | (up_in & clr_up) | (dn_in & clr_dn));
    car_set      = in_door ? (car_req & ~clr_car) : car_req;
    up_set       = in_door ? (up_in & ~clr_up) : up_in;
    dn_set       = in_door ? (dn_in & ~clr_dn) : dn_in;

    if (dir == DIR_DN)
      go_dir = below ? DIR_DN : (above ? DIR_UP : DIR_IDLE);
    else
      go_dir = above ? DIR_UP : (below ? DIR_DN : DIR_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      floor     <= '0;
      dir       <= DIR_IDLE;
      moving    <= 1'b0;
      door_open <= 1'b0;
      pend_car  <= '0;
      pend_up   <= '0;
      pend_dn   <= '0;
      clr_car   <= '0;
      clr_up    <= '0;
      clr_dn    <= '0;
    end else begin
      pend_car <= (pend_car | car_set) & ~ent_car;
      pend_up  <= (pend_up  | up_set)  & ~ent_up;
      pend_dn  <= (pend_dn  | dn_set)  & ~ent_dn;

      case (state)
        S_IDLE: begin
          if (here) begin
            state     <= S_DOOR;
            door_open <= 1'b1;
            cnt       <= DOOR_INIT;
            clr_car   <= ent_car;
            clr_up    <= ent_up;
            clr_dn    <= ent_dn;
          end else if (above || below) begin
            state  <= S_MOVE;
            moving <= 1'b1;
            dir    <= above ? DIR_UP : DIR_DN;
            cnt    <= TRAVEL_INIT;
          end
        end

        S_MOVE: begin
          if (cnt == '0) begin
            floor <= nf;
            if (stop_nf) begin
              state     <= S_DOOR;
              moving    <= 1'b0;
              door_open <= 1'b1;
              cnt       <= DOOR_INIT;
              clr_car   <= ent_car;
              clr_up    <= ent_up;
              clr_dn    <= ent_dn;
            end else begin
              cnt <= TRAVEL_INIT;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_DOOR: begin
          if (door_hold || press_reload) begin
            cnt <= DOOR_INIT;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            door_open <= 1'b0;
            clr_car   <= '0;
            clr_up    <= '0;
            clr_dn    <= '0;
            dir       <= go_dir;
            if (go_dir != DIR_IDLE) begin
              state  <= S_MOVE;
              moving <= 1'b1;
              cnt    <= TRAVEL_INIT;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          moving    <= 1'b0;
          door_open <= 1'b0;
          dir       <= DIR_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_elevator_scan_ctrl.sv
`default_nettype none
// tb_elevator_scan_ctrl : directed scenario checks for elevator_scan_ctrl (8 and 16 floors)
module tb_elevator_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  car_req, hall_up, hall_dn;
  logic        door_hold;
  logic [2:0]  floor;
  logic [1:0]  dir;
  logic        moving, door_open;
  logic [7:0]  pend_car, pend_up, pend_dn;

  logic [15:0] car_req16, hall_up16, hall_dn16;
  logic        door_hold16;
  logic [3:0]  floor16;
  logic [1:0]  dir16;
  logic        moving16, door_open16;
  logic [15:0] pend_car16, pend_up16, pend_dn16;

  int n_tests = 0;
  int n_fail  = 0;

  elevator_scan_ctrl #(.FLOORS(8), .FLOOR_W(3), .TRAVEL_CYC(4), .DOOR_CYC(8)) u_dut (
    .clk(clk), .reset(reset), .car_req(car_req), .hall_up(hall_up), .hall_dn(hall_dn),
    .door_hold(door_hold), .floor(floor), .dir(dir), .moving(moving), .door_open(door_open),
    .pend_car(pend_car), .pend_up(pend_up), .pend_dn(pend_dn)
  );

  elevator_scan_ctrl #(.FLOORS(16), .FLOOR_W(4), .TRAVEL_CYC(4), .DOOR_CYC(8)) u_dut16 (
    .clk(clk), .reset(reset), .car_req(car_req16), .hall_up(hall_up16), .hall_dn(hall_dn16),
    .door_hold(door_hold16), .floor(floor16), .dir(dir16), .moving(moving16),
    .door_open(door_open16), .pend_car(pend_car16), .pend_up(pend_up16), .pend_dn(pend_dn16)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    car_req = '0; hall_up = '0; hall_dn = '0; door_hold = 1'b0;
    car_req16 = '0; hall_up16 = '0; hall_dn16 = '0; door_hold16 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (floor !== 3'd0 || dir !== 2'b00 || moving !== 1'b0 || door_open !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: floor=%0d dir=%b moving=%b door=%b, expected 0 00 0 0",
               floor, dir, moving, door_open);
    end
    n_tests++;
    if ({pend_car, pend_up, pend_dn} !== 24'h0 || floor16 !== 4'd0 || moving16 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pending: car=%h up=%h dn=%h floor16=%0d, expected all 0",
               pend_car, pend_up, pend_dn, floor16);
    end
  endtask

  task automatic test_single_trip();
    int first1 = -1, first5 = -1, dcnt = 0, both = 0;
    logic [7:0] pc21 = 8'hff;
    car_req = 8'h20;
    tick();
    car_req = '0;
    n_tests++;
    if (pend_car !== 8'h20 || moving !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latch: pend_car=%h moving=%b, expected 20 0", pend_car, moving);
    end
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (floor == 3'd1 && first1 < 0) first1 = k;
      if (floor == 3'd5 && first5 < 0) first5 = k;
      if (door_open) dcnt++;
      if (moving && door_open) both++;
      if (k == 21) pc21 = pend_car;
    end
    n_tests++;
    if (first1 != 5 || first5 != 21) begin
      n_fail++;
      $display("FAIL single_timing: floor1 at %0d floor5 at %0d, expected 5 and 21", first1, first5);
    end
    n_tests++;
    if (dcnt != 8 || pc21 !== 8'h00 || both != 0) begin
      n_fail++;
      $display("FAIL single_door: open cycles=%0d pend_car=%h overlap=%0d, expected 8 00 0",
               dcnt, pc21, both);
    end
    n_tests++;
    if (dir !== 2'b00 || moving !== 1'b0 || door_open !== 1'b0 || floor !== 3'd5) begin
      n_fail++;
      $display("FAIL single_idle: dir=%b moving=%b door=%b floor=%0d, expected 00 0 0 5",
               dir, moving, door_open, floor);
    end
  endtask

  task automatic test_pass_by();
    int nd = 0;
    int dfl[2] = '{-1, -1};
    int dk[2]  = '{-1, -1};
    logic       prev = 1'b0;
    logic [1:0] dir34 = 2'b11;
    logic [7:0] pdn45 = 8'hff;
    apply_reset();
    hall_dn = 8'h08;
    car_req = 8'h40;
    tick();
    hall_dn = '0;
    car_req = '0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (door_open && !prev) begin
        if (nd < 2) begin
          dfl[nd] = int'(floor);
          dk[nd]  = k;
        end
        nd++;
      end
      prev = door_open;
      if (k == 34) dir34 = dir;
      if (k == 45) pdn45 = pend_dn;
    end
    n_tests++;
    if (nd != 2 || dfl[0] != 6 || dk[0] != 25) begin
      n_fail++;
      $display("FAIL passby_first_stop: stops=%0d floor=%0d cycle=%0d, expected 2 stops, 6 at 25",
               nd, dfl[0], dk[0]);
    end
    n_tests++;
    if (dir34 !== 2'b10) begin
      n_fail++;
      $display("FAIL passby_reverse: dir=%b, expected 10", dir34);
    end
    n_tests++;
    if (dfl[1] != 3 || dk[1] != 45 || pdn45 !== 8'h00) begin
      n_fail++;
      $display("FAIL passby_second_stop: floor=%0d cycle=%0d pend_dn=%h, expected 3 45 00",
               dfl[1], dk[1], pdn45);
    end
  endtask

  task automatic test_door_hold();
    int  dcnt;
    logic mv = 1'b0, flbad = 1'b0;
    apply_reset();
    car_req = 8'h04;
    tick();
    car_req = '0;
    for (int k = 1; k <= 20; k++) tick();
    n_tests++;
    if (floor !== 3'd2 || dir !== 2'b00 || door_open !== 1'b0 || moving !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_setup: floor=%0d dir=%b door=%b moving=%b, expected 2 00 0 0",
               floor, dir, door_open, moving);
    end
    hall_up = 8'h04;
    tick();
    hall_up = '0;
    n_tests++;
    if (pend_up !== 8'h04 || door_open !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_latch: pend_up=%h door=%b, expected 04 0", pend_up, door_open);
    end
    tick();
    n_tests++;
    if (door_open !== 1'b1 || floor !== 3'd2 || moving !== 1'b0 || pend_up !== 8'h00) begin
      n_fail++;
      $display("FAIL hold_open_here: door=%b floor=%0d moving=%b pend_up=%h, expected 1 2 0 00",
               door_open, floor, moving, pend_up);
    end
    door_hold = 1'b1;
    dcnt = 1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 20) door_hold = 1'b0;
      if (door_open) dcnt++;
      mv = mv | moving;
      if (floor !== 3'd2) flbad = 1'b1;
    end
    n_tests++;
    if (dcnt != 28 || mv !== 1'b0 || flbad !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_dwell: open cycles=%0d moved=%b floor_changed=%b, expected 28 0 0",
               dcnt, mv, flbad);
    end
  endtask

  task automatic test_priority();
    int nd = 0;
    int dfl[2] = '{-1, -1};
    int dk[2]  = '{-1, -1};
    logic       prev = 1'b0;
    logic [1:0] dir1 = 2'b11;
    car_req = 8'h11;
    tick();
    car_req = '0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == 1) dir1 = dir;
      if (door_open && !prev) begin
        if (nd < 2) begin
          dfl[nd] = int'(floor);
          dk[nd]  = k;
        end
        nd++;
      end
      prev = door_open;
    end
    n_tests++;
    if (dir1 !== 2'b01 || dfl[0] != 4 || dk[0] != 9) begin
      n_fail++;
      $display("FAIL priority_up_first: dir=%b floor=%0d cycle=%0d, expected 01, 4 at 9",
               dir1, dfl[0], dk[0]);
    end
    n_tests++;
    if (nd != 2 || dfl[1] != 0 || dk[1] != 33 || pend_car !== 8'h00) begin
      n_fail++;
      $display("FAIL priority_down_next: stops=%0d floor=%0d cycle=%0d pend_car=%h, expected 2, 0 at 33, 00",
               nd, dfl[1], dk[1], pend_car);
    end
  endtask

  task automatic test_top_boundary();
    int maxf = 0, dk = -1, dfl = -1;
    logic [7:0] pu = 8'h00;
    apply_reset();
    car_req = 8'h80;
    hall_up = 8'h80;
    tick();
    car_req = '0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (int'(floor) > maxf) maxf = int'(floor);
      pu = pu | pend_up;
      if (door_open && dk < 0) begin
        dk  = k;
        dfl = int'(floor);
      end
    end
    hall_up = '0;
    n_tests++;
    if (pu !== 8'h00 || maxf != 7) begin
      n_fail++;
      $display("FAIL top_ignore: pend_up seen=%h max floor=%0d, expected 00 7", pu, maxf);
    end
    n_tests++;
    if (dk != 29 || dfl != 7 || door_open !== 1'b0 || dir !== 2'b00) begin
      n_fail++;
      $display("FAIL top_stop: door at %0d floor %0d, end door=%b dir=%b, expected 29 7 0 00",
               dk, dfl, door_open, dir);
    end
  endtask

  task automatic test_reset_mid_move();
    int k4 = -1;
    apply_reset();
    car_req = 8'h80;
    hall_dn = 8'h20;
    tick();
    car_req = '0;
    hall_dn = '0;
    for (int k = 1; k <= 40 && k4 < 0; k++) begin
      tick();
      if (floor == 3'd4) k4 = k;
    end
    n_tests++;
    if (k4 != 17 || moving !== 1'b1 || pend_car !== 8'h80 || pend_dn !== 8'h20) begin
      n_fail++;
      $display("FAIL midmove_reach: floor4 at %0d moving=%b car=%h dn=%h, expected 17 1 80 20",
               k4, moving, pend_car, pend_dn);
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if (floor !== 3'd0 || {pend_car, pend_up, pend_dn} !== 24'h0 || moving !== 1'b0 ||
        dir !== 2'b00 || door_open !== 1'b0) begin
      n_fail++;
      $display("FAIL midmove_abort: floor=%0d pend=%h/%h/%h moving=%b dir=%b, expected 0 all 0",
               floor, pend_car, pend_up, pend_dn, moving, dir);
    end
    reset = 1'b0;
  endtask

  task automatic test_floors16();
    int   k15 = -1;
    logic mv1 = 1'b0, door15 = 1'b0;
    apply_reset();
    car_req16 = 16'h8000;
    tick();
    car_req16 = '0;
    for (int k = 1; k <= 75; k++) begin
      tick();
      if (k == 1) mv1 = moving16;
      if (floor16 == 4'd15 && k15 < 0) begin
        k15    = k;
        door15 = door_open16;
      end
    end
    n_tests++;
    if (mv1 !== 1'b1 || k15 != 61 || door15 !== 1'b1) begin
      n_fail++;
      $display("FAIL floors16_travel: moving=%b floor15 at %0d door=%b, expected 1 61 1",
               mv1, k15, door15);
    end
  endtask

  initial begin
    test_reset();
    test_single_trip();
    test_pass_by();
    test_door_hold();
    test_priority();
    test_top_boundary();
    test_reset_mid_move();
    test_floors16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
- Parametrised single-car elevator controller for FLOORS floors.
- Latches car-button and hall up/down requests, and schedules the car with SCAN (collective) ordering: it keeps its direction while requests lie ahead, then reverses.
- Models per-floor travel time and door dwell with internal counters.
- Replaces the fixed 8-floor idle/up/down controller; used as the top-level car controller, one instance per shaft.

Parameters:
- FLOORS, 8, number of floors; 2..256.
- FLOOR_W, 3, floor index width; must satisfy 2**FLOOR_W >= FLOORS.
- TRAVEL_CYC, 4, clock cycles to move one floor; >= 1.
- DOOR_CYC, 8, clock cycles the door stays open; >= 1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- car_req  input  FLOORS  in-car button, one bit per floor; level or pulse
- hall_up  input  FLOORS  hall up button per floor; bit FLOORS-1 ignored
- hall_dn  input  FLOORS  hall down button per floor; bit 0 ignored
- door_hold  input  1  door-open/obstruction; while high in DOOR, reloads the dwell counter
- floor  output  FLOOR_W  current car floor, binary
- dir  output  2  00 idle, 01 up, 10 down
- moving  output  1  high in MOVE state
- door_open  output  1  high in DOOR state
- pend_car  output  FLOORS  latched car requests
- pend_up  output  FLOORS  latched hall-up requests
- pend_dn  output  FLOORS  latched hall-down requests

Behaviour:
- All outputs registered.
- Reset values: floor=0, dir=00, moving=0, door_open=0, all pend_* = 0, state IDLE, counters 0.
- Reset mid-travel or mid-door aborts immediately to the reset state.
- Request latching:
  - A 1 on an input bit sets the matching pend bit on the next clock.
  - Bits stay set until serviced.
  - Ignored bits (hall_up[FLOORS-1], hall_dn[0]) never set.
- Helper terms, combinational on pend_* and floor:
  - above = any pending bit of any type at index > floor.
  - below = any pending bit at index < floor.
  - here = car/up/dn pending at floor.
- State IDLE (dir=00):
  - here -> DOOR.
  - else above -> MOVE, dir=01.
  - else below -> MOVE, dir=10.
  - Above has priority over below.
- State MOVE:
  - Travel counter loads TRAVEL_CYC-1 on entry and decrements each cycle.
  - At 0: floor +/-1 per dir, i.e. floor changes exactly TRAVEL_CYC cycles after entering MOVE.
  - On arrival, stop if any of:
    - pend_car[floor];
    - hall pending in the travel direction at floor;
    - (opposite hall pending at floor) and no request further in dir.
  - Stop -> DOOR; otherwise reload counter and continue.
  - floor never leaves 0..FLOORS-1.
- DOOR entry clears:
  - pend_car[floor];
  - same-direction hall bit at floor;
  - opposite hall bit only if nothing is pending beyond in dir. From IDLE (dir=00), both hall bits at floor are cleared.
- State DOOR:
  - door_open=1; dwell counter loads DOOR_CYC-1, decrements each cycle; door_hold reloads it.
  - A new press at floor matching a bit cleared on entry reloads the dwell counter and does not latch.
- DOOR exit at counter 0 (door_hold low):
  - requests beyond in dir -> MOVE, same dir;
  - else requests the other way -> MOVE, reversed dir;
  - else -> IDLE, dir=00.
- Simultaneous set and clear of the same pend bit: clear wins only for the floor being opened; all others set.
- moving and door_open are never both 1.

Test Plan:
- Reset, then car_req[5] pulse at cycle 0 (TRAVEL_CYC=4, DOOR_CYC=8):
  - MOVE up, floor=1 at cycle 5, reaches 5 at cycle 21;
  - door_open 8 cycles, pend_car[5] cleared;
  - then IDLE, dir=00.
- Car at 0, hall_dn[3] and car_req[6] set:
  - passes 3 without stopping, stops at 6;
  - reverses dir=10, stops at 3, pend_dn[3] cleared.
- Car idle at 2, hall_up[2] pressed:
  - DOOR entered without movement, floor stays 2;
  - holding door_hold 20 cycles keeps door_open high 20+8 cycles.
- Car at 7 (FLOORS=8) moving up to 7 with hall_up[7] pressed:
  - never latched;
  - floor never exceeds 7.
- Reset asserted mid-MOVE at floor 4 with pending requests:
  - next cycle floor=0, all pend_* = 0, moving=0, dir=00.
- FLOORS=16, FLOOR_W=4: car_req[15] from 0 -> arrives floor 15 after 60 cycles.
